// File: rtl/vortex_launch_ctrl.sv
// Kernel-launch sequencer: holds Vortex in reset while idle, releases it on start,
// supervises the run until busy drops, and reports done/error/cycles plus an irq pulse.
module vortex_launch_ctrl #(
  parameter int unsigned RESET_HOLD_CYCLES      = 8,
  parameter int unsigned BUSY_WAIT_CYCLES       = 64,
  parameter logic [31:0] PC_RESET_VAL_RESET_VAL = 32'hF000_0000,
  parameter int unsigned CYCLE_CNT_WIDTH        = 32
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       start_req,
  input  logic                       pc_wen,
  input  logic [31:0]                pc_wdata,
  input  logic                       abort,
  input  logic                       done_clr,
  input  logic                       Vortex_busy,
  output logic                       Vortex_reset,
  output logic [31:0]                Vortex_PC_reset_val,
  output logic                       status_busy,
  output logic                       done,
  output logic [1:0]                 err_code,
  output logic [CYCLE_CNT_WIDTH-1:0] cycle_count,
  output logic                       irq
);

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(BUSY_WAIT_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CYCLE_CNT_WIDTH-1:0] CNT_ONE = CYCLE_CNT_WIDTH'(1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RST_HOLD  = 2'd1,
    WAIT_BUSY = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  // Run counter sticks at all-ones rather than wrapping to a misleading small value.
  function automatic logic [CYCLE_CNT_WIDTH-1:0] sat_inc(input logic [CYCLE_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Vortex_reset and status_busy are registered alongside state so they always
  // match the decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state               <= IDLE;
      hold_cnt            <= '0;
      wait_cnt            <= '0;
      Vortex_reset        <= 1'b1;
      Vortex_PC_reset_val <= PC_RESET_VAL_RESET_VAL;
      status_busy         <= 1'b0;
      done                <= 1'b0;
      err_code            <= ERR_NONE;
      cycle_count         <= '0;
      irq                 <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_wen) begin
            Vortex_PC_reset_val <= pc_wdata;
          end
          if (start_req) begin
            state        <= RST_HOLD;
            hold_cnt     <= HOLD_LOAD;
            done         <= 1'b0;
            err_code     <= ERR_NONE;
            cycle_count  <= '0;
            status_busy  <= 1'b1;
            Vortex_reset <= 1'b1;
          end else if (done_clr) begin
            done     <= 1'b0;
            err_code <= ERR_NONE;
          end
        end

        RST_HOLD: begin
          if (abort) begin
            state        <= IDLE;
            err_code     <= ERR_ABORT;
            irq          <= 1'b1;
            status_busy  <= 1'b0;
            Vortex_reset <= 1'b1;
          end else if (hold_cnt == '0) begin
            state        <= WAIT_BUSY;
            wait_cnt     <= '0;
            Vortex_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end
        end

        WAIT_BUSY: begin
          if (abort) begin
            state        <= IDLE;
            err_code     <= ERR_ABORT;
            irq          <= 1'b1;
            status_busy  <= 1'b0;
            Vortex_reset <= 1'b1;
          end else if (Vortex_busy) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state        <= IDLE;
            err_code     <= ERR_TIMEOUT;
            irq          <= 1'b1;
            status_busy  <= 1'b0;
            Vortex_reset <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end

        RUN: begin
          if (abort) begin
            state        <= IDLE;
            err_code     <= ERR_ABORT;
            irq          <= 1'b1;
            status_busy  <= 1'b0;
            Vortex_reset <= 1'b1;
          end else if (!Vortex_busy) begin
            state        <= IDLE;
            done         <= 1'b1;
            irq          <= 1'b1;
            status_busy  <= 1'b0;
            Vortex_reset <= 1'b1;
          end else begin
            cycle_count <= sat_inc(cycle_count);
          end
        end

        default: begin
          state        <= IDLE;
          status_busy  <= 1'b0;
          Vortex_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vortex_launch_ctrl.sv
// Directed bench for vortex_launch_ctrl: normal run, busy timeout, abort,
// ignored writes during a launch, and reset in the middle of a launch.
module tb_vortex_launch_ctrl;

  logic        clk = 1'b0;
  logic        nRST;
  logic        start_req;
  logic        pc_wen;
  logic [31:0] pc_wdata;
  logic        abort;
  logic        done_clr;
  logic        Vortex_busy;
  logic        Vortex_reset;
  logic [31:0] Vortex_PC_reset_val;
  logic        status_busy;
  logic        done;
  logic [1:0]  err_code;
  logic [31:0] cycle_count;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;
  int hi_cnt;

  vortex_launch_ctrl dut (
    .clk                 (clk),
    .nRST                (nRST),
    .start_req           (start_req),
    .pc_wen              (pc_wen),
    .pc_wdata            (pc_wdata),
    .abort               (abort),
    .done_clr            (done_clr),
    .Vortex_busy         (Vortex_busy),
    .Vortex_reset        (Vortex_reset),
    .Vortex_PC_reset_val (Vortex_PC_reset_val),
    .status_busy         (status_busy),
    .done                (done),
    .err_code            (err_code),
    .cycle_count         (cycle_count),
    .irq                 (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; start_req = 1'b0; pc_wen = 1'b0; pc_wdata = '0;
    abort = 1'b0; done_clr = 1'b0; Vortex_busy = 1'b0;
    tick(2);
    chk("rst_vreset", 32'(Vortex_reset), 32'd1);
    chk("rst_pc",     Vortex_PC_reset_val, 32'hF000_0000);
    chk("rst_cnt",    cycle_count, 32'd0);
    nRST = 1'b1;
    tick(5);
    chk("idle_vreset", 32'(Vortex_reset), 32'd1);
    chk("idle_pc",     Vortex_PC_reset_val, 32'hF000_0000);
    chk("idle_busy",   32'(status_busy), 32'd0);
    chk("idle_done",   32'(done), 32'd0);
    chk("idle_err",    32'(err_code), 32'd0);
    chk("idle_irq",    32'(irq), 32'd0);

    // Normal launch from PC 8000_0000
    pc_wen = 1'b1; pc_wdata = 32'h8000_0000;
    tick(1);
    pc_wen = 1'b0;
    chk("pc_load", Vortex_PC_reset_val, 32'h8000_0000);
    tick(1);
    pulse_start();
    chk("start_busy", 32'(status_busy), 32'd1);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (Vortex_reset) hi_cnt++;
      tick(1);
    end
    chk("hold_len",     32'(hi_cnt), 32'd8);
    chk("release",      32'(Vortex_reset), 32'd0);
    tick(2);
    Vortex_busy = 1'b1;
    tick(1);
    chk("run_entry_cnt", cycle_count, 32'd0);
    // 100 busy-high samples while in RUN
    tick(100);
    chk("run_cnt",   cycle_count, 32'd100);
    chk("run_pc",    Vortex_PC_reset_val, 32'h8000_0000);
    chk("run_irq0",  32'(irq), 32'd0);
    Vortex_busy = 1'b0;
    tick(1);
    chk("cmp_done",   32'(done), 32'd1);
    chk("cmp_irq",    32'(irq), 32'd1);
    chk("cmp_vreset", 32'(Vortex_reset), 32'd1);
    chk("cmp_busy",   32'(status_busy), 32'd0);
    chk("cmp_cnt",    cycle_count, 32'd100);
    chk("cmp_err",    32'(err_code), 32'd0);
    tick(1);
    chk("cmp_irq_pulse", 32'(irq), 32'd0);
    chk("cmp_done_stick", 32'(done), 32'd1);

    // Busy timeout: 8 hold + 64 wait cycles
    pulse_start();
    chk("to_done_clr", 32'(done), 32'd0);
    tick(71);
    chk("to_still_busy", 32'(status_busy), 32'd1);
    chk("to_no_irq",     32'(irq), 32'd0);
    tick(1);
    chk("to_idle",   32'(status_busy), 32'd0);
    chk("to_err",    32'(err_code), 32'd1);
    chk("to_done",   32'(done), 32'd0);
    chk("to_irq",    32'(irq), 32'd1);
    chk("to_vreset", 32'(Vortex_reset), 32'd1);
    tick(1);
    chk("to_irq_pulse", 32'(irq), 32'd0);

    // Abort after 20 run cycles
    pulse_start();
    chk("ab_err_clr", 32'(err_code), 32'd0);
    tick(8);
    Vortex_busy = 1'b1;
    tick(1);
    tick(20);
    chk("ab_pre_cnt", cycle_count, 32'd20);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_idle",   32'(status_busy), 32'd0);
    chk("ab_vreset", 32'(Vortex_reset), 32'd1);
    chk("ab_err",    32'(err_code), 32'd2);
    chk("ab_cnt",    cycle_count, 32'd20);
    chk("ab_irq",    32'(irq), 32'd1);
    chk("ab_done",   32'(done), 32'd0);
    tick(1);
    chk("ab_irq_pulse", 32'(irq), 32'd0);
    Vortex_busy = 1'b0;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_idle_ignored_err", 32'(err_code), 32'd2);
    chk("ab_idle_ignored_irq", 32'(irq), 32'd0);

    // Second launch: writes during RUN are ignored
    pulse_start();
    chk("l2_err_clr", 32'(err_code), 32'd0);
    chk("l2_cnt_clr", cycle_count, 32'd0);
    tick(8);
    Vortex_busy = 1'b1;
    tick(1);
    pc_wen = 1'b1; pc_wdata = 32'h1234_5678; start_req = 1'b1; done_clr = 1'b1;
    tick(1);
    pc_wen = 1'b0; start_req = 1'b0; done_clr = 1'b0;
    chk("l2_pc_stable", Vortex_PC_reset_val, 32'h8000_0000);
    chk("l2_cnt1",      cycle_count, 32'd1);
    chk("l2_busy",      32'(status_busy), 32'd1);
    tick(4);
    Vortex_busy = 1'b0;
    tick(1);
    chk("l2_done", 32'(done), 32'd1);
    chk("l2_irq",  32'(irq), 32'd1);
    chk("l2_cnt",  cycle_count, 32'd5);
    done_clr = 1'b1;
    tick(1);
    done_clr = 1'b0;
    chk("dclr_done", 32'(done), 32'd0);
    chk("dclr_err",  32'(err_code), 32'd0);

    // nRST pulse during RST_HOLD
    pulse_start();
    tick(2);
    chk("nrst_pre_busy", 32'(status_busy), 32'd1);
    nRST = 1'b0;
    tick(1);
    nRST = 1'b1;
    chk("nrst_busy",   32'(status_busy), 32'd0);
    chk("nrst_vreset", 32'(Vortex_reset), 32'd1);
    chk("nrst_pc",     Vortex_PC_reset_val, 32'hF000_0000);
    chk("nrst_irq",    32'(irq), 32'd0);
    chk("nrst_cnt",    cycle_count, 32'd0);
    tick(10);
    chk("nrst_stay_idle",   32'(status_busy), 32'd0);
    chk("nrst_stay_vreset", 32'(Vortex_reset), 32'd1);
    chk("nrst_stay_irq",    32'(irq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
